lshift_seq_ctrl: RTL and testbench
==================================

Name: lshift_seq_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 8-bit combinational logical left shifter (3-bit amount, 0..7) and consumes its result.
- Accepts an 8-bit operand and a 5-bit shift amount (0..31) over a valid/ready handshake.
- Decomposes the amount into shifter passes of at most 7, iterating the operand through the shifter once per clock.
- Returns the final result over a second valid/ready handshake.

Parameters:
- DW, 8, operand/result width; fixed to the shifter width, no other value supported.
- AW, 5, request shift-amount width.
- MAX_STEP, 7, largest amount issued to the shifter per pass; must fit in 3 bits (1..7).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_data  input  DW  operand.
- in_amt  input  AW  total left-shift amount.
- sh_data  output  DW  operand driven to shifter data input.
- sh_lsel  output  3  amount driven to shifter select input.
- sh_out  input  DW  shifter combinational result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  DW  final shifted result.
- out_ovf  output  1  request amount was >= DW (result necessarily 0).
- done_cnt  output  8  completed-transaction counter.

Behaviour:
- Clocking/reset: one clock; synchronous active-high reset.
- Reset state (rst high at an edge):
  - state=IDLE; acc=0; rem=0; out_data=0; out_ovf=0; done_cnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, sh_lsel=0, sh_data=0.
- Reset has priority over every other event, including mid-SHIFT and mid-DONE. An in-flight request is discarded with no output and no count.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready: acc<=in_data; rem<=in_amt; out_ovf<=(in_amt>=DW).
  - If in_amt==0, go to DONE with out_data<=in_data. Otherwise go to SHIFT.
- State SHIFT:
  - in_ready=0.
  - step = min(rem, MAX_STEP); sh_data=acc; sh_lsel=step (combinational).
  - Each cycle: acc<=sh_out; rem<=rem-step.
  - When rem==step: out_data<=sh_out and go to DONE.
  - No zero short-cut: every pass is issued even when acc is already 0.
- State DONE:
  - out_valid=1; in_ready=0; out_data and out_ovf held stable.
  - On out_ready: done_cnt<=done_cnt+1 (8-bit wrap, 255->0); go to IDLE.
- Outside SHIFT: sh_lsel=0 and sh_data=acc.
- Latency: request accepted at edge N; k=ceil(in_amt/MAX_STEP) SHIFT cycles; out_valid first high in cycle N+k+1. For in_amt=0, out_valid is high in cycle N+1.
- Throughput: one request in flight. The next request can be accepted at the earliest one cycle after the out handshake (in_ready is 0 during the handshake cycle).
- in_valid while in_ready=0 is ignored; the requester must hold the request.
- out_valid, once asserted, stays high until the handshake completes.
- out_ready while out_valid=0 has no effect.
- Arithmetic: shifter result is DW bits; bits shifted past bit DW-1 are lost; zeros fill from the LSB. rem arithmetic is AW bits and never underflows.

Test Plan:
- in_data=0xB5, in_amt=3, out_ready=1 -> one SHIFT cycle with sh_lsel=3; out_data=0xA8, out_ovf=0, out_valid at N+2; done_cnt=1.
- in_data=0x3C, in_amt=0 -> no SHIFT cycle; sh_lsel stays 0; out_data=0x3C at N+1.
- in_data=0x01, in_amt=10 -> sh_lsel sequence 7,3; intermediate acc=0x80; out_data=0x00, out_ovf=1, out_valid at N+3.
- in_data=0xFF, in_amt=31 -> sh_lsel sequence 7,7,7,7,3 (5 passes); out_data=0x00, out_ovf=1, out_valid at N+6.
- Backpressure: in_data=0x0F, in_amt=4, out_ready low for 5 cycles -> out_data=0xF0 held and out_valid high throughout; in_ready=0 and a new in_valid is ignored; accepted one cycle after out_ready rises.
- Reset mid-SHIFT (in_amt=20, rst at second pass) -> next cycle: in_ready=1, out_valid=0, sh_lsel=0, done_cnt unchanged at 0, no output. Then 256 back-to-back amt=1 transactions -> done_cnt wraps to 0.

Source files
------------

// File: rtl/lshift_seq_ctrl.sv
// Sequencing controller for an external 8-bit, 3-bit-amount combinational left
// shifter: splits a 0..31 shift into passes of at most MAX_STEP, one per clock.
module lshift_seq_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int MAX_STEP = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_amt,
  output logic [DW-1:0] sh_data,
  output logic [2:0]    sh_lsel,
  input  logic [DW-1:0] sh_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ovf,
  output logic [7:0]    done_cnt,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a raised valid holds until it transfers.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] DW_AMT   = AW'(DW);
  localparam logic [AW-1:0] STEP_MAX = AW'(MAX_STEP);

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;
  logic [7:0]    done_cnt_q, done_cnt_d;
  logic [AW-1:0] step;

  assign step = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    done_cnt_d = done_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sh_lsel    = 3'd0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d     = in_data;
          rem_d     = in_amt;
          out_ovf_d = (in_amt >= DW_AMT);
          if (in_amt == '0) begin
            out_data_d = in_data;
            state_d    = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Every pass is issued even once acc has shifted out to zero.
        sh_lsel = step[2:0];
        acc_d   = sh_out;
        rem_d   = rem_q - step;
        if (rem_q == step) begin
          out_data_d = sh_out;
          state_d    = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sh_data   = acc_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign done_cnt  = done_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lshift_seq_ctrl.sv
// Bench for lshift_seq_ctrl: directed and random requests against a
// shift-by-amount reference model, with backpressure and reset recovery.
module tb_lshift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic [7:0] sh_data;
  logic [2:0] sh_lsel;
  logic [7:0] sh_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic [7:0] done_cnt;
  logic [1:0] dbg_state;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt;
  logic [2:0] exp_q[$];

  lshift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .sh_data   (sh_data),
    .sh_lsel   (sh_lsel),
    .sh_out    (sh_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .done_cnt  (done_cnt),
    .dbg_state (dbg_state)
  );

  // The external shifter the controller drives.
  assign sh_out = sh_data << sh_lsel;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request: accept, follow each pass, wait `hold` cycles of
  // backpressure (with a junk request offered), then complete the handshake.
  task automatic run_txn(input logic [7:0] d, input logic [4:0] a, input int hold);
    logic [7:0] acc;
    logic [7:0] exp_out;
    int         r;
    int         k;
    int         cyc;
    exp_q.delete();
    r = a;
    k = 0;
    while (r > 0) begin
      exp_q.push_back(3'((r > 7) ? 7 : r));
      r -= (r > 7) ? 7 : r;
      k++;
    end
    exp_out = (a >= 5'd8) ? 8'h00 : 8'(d << a);
    acc = d;

    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
    in_amt   = $urandom_range(0, 31);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk("shift_in_ready", in_ready, 0);
      chk("shift_sh_data", sh_data, acc);
      if (exp_q.size() > 0) begin
        chk("shift_lsel", sh_lsel, exp_q.pop_front());
        acc = acc << sh_lsel;
      end else begin
        chk("extra_pass", sh_lsel, 0);
      end
      tick();
      cyc++;
    end
    chk("latency", cyc, k + 1);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp_out);
    chk("out_ovf", out_ovf, (a >= 5'd8));
    chk("done_lsel", sh_lsel, 0);
    chk("done_in_ready", in_ready, 0);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp_out);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("done_cnt", done_cnt, exp_cnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 5'd0;
    out_ready = 1'b0;
    exp_cnt   = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lsel", sh_lsel, 0);
    chk("rst_sh_data", sh_data, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_cnt", done_cnt, 0);

    run_txn(8'hB5, 5'd3, 0);
    run_txn(8'h3C, 5'd0, 0);
    run_txn(8'h01, 5'd10, 0);
    run_txn(8'hFF, 5'd31, 0);
    run_txn(8'h0F, 5'd4, 5);
    run_txn(8'h81, 5'd7, 1);
    run_txn(8'h81, 5'd8, 0);
    run_txn(8'hC3, 5'd14, 2);

    for (int i = 0; i < 40; i++)
      run_txn(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 3));

    // Reset during the second pass of a 20-bit shift.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_amt   = 5'd20;
    tick();
    in_valid = 1'b0;
    chk("mid_lsel1", sh_lsel, 7);
    tick();
    chk("mid_lsel2", sh_lsel, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_lsel", sh_lsel, 0);
    chk("mid_rst_cnt", done_cnt, 0);
    tick();
    chk("mid_rst_quiet", out_valid, 0);

    for (int i = 0; i < 256; i++)
      run_txn(8'($urandom_range(0, 255)), 5'd1, 0);
    chk("cnt_wrap", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
